// File: rtl/mux_4_arbiter_pkg.sv
// Shared types, sizes and the round-robin pick helper for the 4:1 mux arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int NUM_REQ  = 4;
  localparam int REQ_ID_W = 2;

  // Returns {found, idx}. The scan runs from lowest to highest priority so the
  // last hit (offset ptr+1) wins; offset 4 wraps to ptr itself.
  function automatic logic [REQ_ID_W:0] rr_pick(input logic [NUM_REQ-1:0]  req,
                                                input logic [REQ_ID_W-1:0] ptr);
    logic [REQ_ID_W:0]   res;
    logic [REQ_ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + REQ_ID_W'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4_arbiter_if.sv
// Requester/consumer bundle for the arbiter; master is the environment side.
interface mux_4_arbiter_if #(parameter int DATA_WIDTH = 16);
  import arb_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [DATA_WIDTH-1:0] din_0;
  logic [DATA_WIDTH-1:0] din_1;
  logic [DATA_WIDTH-1:0] din_2;
  logic [DATA_WIDTH-1:0] din_3;
  logic                  out_ready;
  logic [NUM_REQ-1:0]    gnt;
  logic [REQ_ID_W-1:0]   sel;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  busy;

  modport master (
    output req, lock, din_0, din_1, din_2, din_3, out_ready,
    input  gnt, sel, out_valid, dout, busy
  );

  modport slave (
    input  req, lock, din_0, din_1, din_2, din_3, out_ready,
    output gnt, sel, out_valid, dout, busy
  );

endinterface

// File: rtl/mux_4_arbiter_mux.sv
// Plain combinational 4:1 data mux used on the shared output channel.
module mux_4 #(
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] din_0,
  input  logic [data_width-1:0] din_1,
  input  logic [data_width-1:0] din_2,
  input  logic [data_width-1:0] din_3,
  input  logic [1:0]            sel,
  output logic [data_width-1:0] mux_out
);

  always_comb begin
    unique case (sel)
      2'd0: mux_out = din_0;
      2'd1: mux_out = din_1;
      2'd2: mux_out = din_2;
      2'd3: mux_out = din_3;
    endcase
  end

endmodule

// File: rtl/mux_4_arbiter.sv
// Round-robin arbiter with capped locked bursts driving a shared 4:1 data mux.
module mux_4_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input logic             clk,
  input logic             reset,
  mux_4_arbiter_if.slave  bus
);

  localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0]  gnt, gnt_nxt;
  logic [REQ_ID_W-1:0] sel, sel_nxt;
  logic [REQ_ID_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;

  logic                beat;
  logic                release_now;
  logic [REQ_ID_W:0]   pick_idle;
  logic [REQ_ID_W:0]   pick_rel;

  // After a release the old holder (sel) becomes the new ptr, so the
  // same-cycle re-arbitration scans from sel rather than the stale ptr.
  assign pick_idle = rr_pick(bus.req, ptr);
  assign pick_rel  = rr_pick(bus.req, sel);

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    beat         = 1'b0;
    release_now  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_idle[REQ_ID_W]) begin
          state_nxt    = ARB_GRANT;
          sel_nxt      = pick_idle[REQ_ID_W-1:0];
          gnt_nxt      = NUM_REQ'(1) << pick_idle[REQ_ID_W-1:0];
          beat_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        beat        = bus.req[sel] && bus.out_ready;
        release_now = !bus.req[sel] ||
                      (beat && (!bus.lock[sel] || beat_cnt == CNT_LAST));
        if (release_now) begin
          ptr_nxt      = sel;
          beat_cnt_nxt = '0;
          if (pick_rel[REQ_ID_W]) begin
            sel_nxt = pick_rel[REQ_ID_W-1:0];
            gnt_nxt = NUM_REQ'(1) << pick_rel[REQ_ID_W-1:0];
          end else begin
            state_nxt = ARB_IDLE;
            gnt_nxt   = '0;
          end
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= REQ_ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.sel       = sel;
  assign bus.busy      = (state == ARB_GRANT);
  assign bus.out_valid = (state == ARB_GRANT) && bus.req[sel];

  mux_4 #(.data_width(DATA_WIDTH)) u_mux (
    .din_0   (bus.din_0),
    .din_1   (bus.din_1),
    .din_2   (bus.din_2),
    .din_3   (bus.din_3),
    .sel     (sel),
    .mux_out (bus.dout)
  );

endmodule
